// File: rtl/drive_status_display.sv
// drive_status_display: turn-signal blinker, BCD odometer and 4-digit multiplexed
//   seven-segment display of the odometer, driven by the manual-driving FSM.
// Ports: clk/rst (sync, active-high); drive_state (one-hot mode), move_cmd
//   {right,left,back,fwd}; led_left/led_right; mileage_bcd; seg_an/seg_cat.
// Optional build macro ODO_LEAD_BLANK_EN blanks leading zero digits (digit 0 always shown).
// All outputs are registered. There is no backpressure; inputs are sampled every cycle.
module drive_status_display #(
  parameter int BLINK_HALF_CYCLES = 50_000_000,
  parameter int METER_TICK_CYCLES = 100_000_000,
  parameter int SCAN_CYCLES       = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  drive_state,
  input  logic [3:0]  move_cmd,
  output logic        led_left,
  output logic        led_right,
  output logic [15:0] mileage_bcd,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int TW = (METER_TICK_CYCLES > 1) ? $clog2(METER_TICK_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(METER_TICK_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);

  // Odometer mode is a pure decode of the current inputs; it is re-evaluated every cycle.
  typedef enum logic [1:0] {MODE_OFF, MODE_IDLE, MODE_RUN} mode_e;
  mode_e mode;

  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   mileage_q, mileage_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          turn_act_q, turn_act;
  logic          led_left_q, led_left_d, led_right_q, led_right_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    scan_idx_q, scan_idx_d;
  logic [3:0]    seg_an_q, seg_an_d;
  logic [7:0]    seg_cat_q, seg_cat_d;
  logic [3:0]    digit;
  logic          blank_digit;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Non-one-hot drive_state values fall through to IDLE (treated as unstarting).
  always_comb begin
    mode = MODE_IDLE;
    if (drive_state == 4'b1000) begin
      mode = MODE_OFF;
    end else if ((drive_state == 4'b0100) && (move_cmd[1] | move_cmd[0])) begin
      mode = MODE_RUN;
    end
  end

  // Odometer: partial units survive IDLE, everything clears while powered off.
  always_comb begin
    tick_d    = tick_q;
    mileage_d = mileage_q;
    case (mode)
      MODE_OFF: begin
        tick_d    = '0;
        mileage_d = 16'h0000;
      end
      MODE_RUN: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          mileage_d = bcd_inc(mileage_q);
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Blinker: turn_act_q detects the start of an active run so the LED lights immediately.
  assign turn_act = move_cmd[3] | move_cmd[2];

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (turn_act && !turn_act_q) begin
      phase_d = 1'b1;
    end else if (turn_act) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
    led_left_d  = move_cmd[2] & phase_d;
    led_right_d = move_cmd[3] & phase_d;
  end

  // Display scan: segment registers follow the current index, so they lag it by one cycle.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end

    digit = mileage_q[{scan_idx_q, 2'b00} +: 4];
`ifdef ODO_LEAD_BLANK_EN
    // A digit is leading-zero when it and every more significant digit are zero.
    blank_digit = ((scan_idx_q == 2'd3) && (mileage_q[15:12] == 4'd0)) ||
                  ((scan_idx_q == 2'd2) && (mileage_q[15:8]  == 8'd0)) ||
                  ((scan_idx_q == 2'd1) && (mileage_q[15:4]  == 12'd0));
`else
    blank_digit = 1'b0;
`endif

    seg_an_d  = 4'b0001 << scan_idx_q;
    seg_cat_d = blank_digit ? 8'h00 : seg_code(digit);
    if (mode == MODE_OFF) begin
      seg_an_d  = 4'b0000;
      seg_cat_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      mileage_q   <= 16'h0000;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      turn_act_q  <= 1'b0;
      led_left_q  <= 1'b0;
      led_right_q <= 1'b0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= 2'd0;
      seg_an_q    <= 4'b0001;
      seg_cat_q   <= 8'h3F;
    end else begin
      tick_q      <= tick_d;
      mileage_q   <= mileage_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      turn_act_q  <= turn_act;
      led_left_q  <= led_left_d;
      led_right_q <= led_right_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      seg_an_q    <= seg_an_d;
      seg_cat_q   <= seg_cat_d;
    end
  end

  assign led_left    = led_left_q;
  assign led_right   = led_right_q;
  assign mileage_bcd = mileage_q;
  assign seg_an      = seg_an_q;
  assign seg_cat     = seg_cat_q;

endmodule

// File: tb/tb_drive_status_display.sv
module tb_drive_status_display;

  localparam int BH = 4;
  localparam int MT = 10;
  localparam int SC = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  drive_state;
  logic [3:0]  move_cmd;
  logic        led_left, led_right;
  logic [15:0] mileage_bcd;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  // Second instance with a 2-cycle odometer unit, used to reach 9999 and its wrap.
  logic        w_rst;
  logic        w_led_left, w_led_right;
  logic [15:0] w_mileage;
  logic [3:0]  w_seg_an;
  logic [7:0]  w_seg_cat;

  int vectors;
  int miscompares;

  // Reference model state
  int         m_tick, m_mil, m_run, m_scan, w_n;
  logic       e_led_l, e_led_r;
  logic [3:0] e_an;
  logic [7:0] e_cat;

  logic [7:0] segtab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  drive_status_display #(.BLINK_HALF_CYCLES(BH), .METER_TICK_CYCLES(MT), .SCAN_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .drive_state(drive_state), .move_cmd(move_cmd),
    .led_left(led_left), .led_right(led_right), .mileage_bcd(mileage_bcd),
    .seg_an(seg_an), .seg_cat(seg_cat)
  );

  drive_status_display #(.BLINK_HALF_CYCLES(BH), .METER_TICK_CYCLES(2), .SCAN_CYCLES(SC)) dut_w (
    .clk(clk), .rst(w_rst), .drive_state(4'b0100), .move_cmd(4'b0001),
    .led_left(w_led_left), .led_right(w_led_right), .mileage_bcd(w_mileage),
    .seg_an(w_seg_an), .seg_cat(w_seg_cat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p10(input int i);
    int r;
    r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int m);
    return {4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction

  function automatic logic [7:0] seg_of(input int m, input int idx);
`ifdef ODO_LEAD_BLANK_EN
    if (idx > 0 && m < p10(idx)) return 8'h00;
`endif
    return segtab[(m / p10(idx)) % 10];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mileage as an integer, blink phase from the length of the current turn run,
  // scan index from the number of cycles since reset.
  task automatic model_update(input logic r, input logic [3:0] ds, input logic [3:0] cmd);
    bit off, run, act;
    int idx;
    if (r) begin
      m_tick = 0; m_mil = 0; m_run = 0; m_scan = 0;
      e_led_l = 1'b0; e_led_r = 1'b0; e_an = 4'b0001; e_cat = 8'h3F;
    end else begin
      off = (ds == 4'b1000);
      run = (ds == 4'b0100) && (cmd[0] || cmd[1]);
      idx = (m_scan / SC) % 4;
      if (off) begin
        e_an = 4'b0000; e_cat = 8'h00;
      end else begin
        e_an = 4'(1 << idx); e_cat = seg_of(m_mil, idx);
      end
      m_scan++;
      if (off) begin
        m_tick = 0; m_mil = 0;
      end else if (run) begin
        m_tick++;
        if (m_tick == MT) begin
          m_tick = 0;
          m_mil = (m_mil + 1) % 10000;
        end
      end
      act = cmd[3] || cmd[2];
      m_run = act ? m_run + 1 : 0;
      e_led_l = act && cmd[2] && (((m_run - 1) / BH) % 2 == 0);
      e_led_r = act && cmd[3] && (((m_run - 1) / BH) % 2 == 0);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] ds, input logic [3:0] cmd);
    rst = r; drive_state = ds; move_cmd = cmd;
    @(posedge clk);
    model_update(r, ds, cmd);
    if (w_rst) w_n = 0; else w_n++;
    #1;
    chk("led_left", 32'(led_left), 32'(e_led_l));
    chk("led_right", 32'(led_right), 32'(e_led_r));
    chk("mileage", 32'(mileage_bcd), 32'(to_bcd(m_mil)));
    chk("seg_an", 32'(seg_an), 32'(e_an));
    chk("seg_cat", 32'(seg_cat), 32'(e_cat));
    chk("w_mileage", 32'(w_mileage), 32'(to_bcd((w_n / 2) % 10000)));
    chk("w_leds", 32'({w_led_left, w_led_right}), 32'(0));
    chk("w_scan_onehot", 32'($countones(w_seg_an)), 32'(1));
    chk("w_dp", 32'(w_seg_cat[7]), 32'(0));
    if (w_n == 20)    chk("wrap_0009_to_0010", 32'(w_mileage), 32'h0010);
    if (w_n == 2000)  chk("wrap_0999_to_1000", 32'(w_mileage), 32'h1000);
    if (w_n == 19998) chk("wrap_at_9999", 32'(w_mileage), 32'h9999);
    if (w_n == 20000) chk("wrap_9999_to_0000", 32'(w_mileage), 32'h0000);
  endtask

  // Reset with arbitrary inputs; outputs must reach their reset values regardless.
  task automatic do_reset();
    step(1'b1, 4'($urandom), 4'($urandom));
    step(1'b1, 4'($urandom), 4'($urandom));
    chk("rst_leds", 32'({led_left, led_right}), 32'(0));
    chk("rst_mileage", 32'(mileage_bcd), 32'h0000);
    chk("rst_seg_an", 32'(seg_an), 32'h1);
    chk("rst_seg_cat", 32'(seg_cat), 32'h3F);
  endtask

  task automatic run_n(input int n, input logic [3:0] ds, input logic [3:0] cmd);
    for (int i = 0; i < n; i++) step(1'b0, ds, cmd);
  endtask

  initial begin
    logic [3:0]  an_seq [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
    logic [11:0] blink_pat;
    logic [7:0]  lz, exp_cat;
    logic [3:0]  ds, cmd;
    int          an_cnt [4];

    vectors = 0; miscompares = 0;
    rst = 1'b1; drive_state = 4'b0001; move_cmd = 4'b0000; w_rst = 1'b1;
    m_tick = 0; m_mil = 0; m_run = 0; m_scan = 0; w_n = 0;
    e_led_l = 1'b0; e_led_r = 1'b0; e_an = 4'b0001; e_cat = 8'h3F;
`ifdef ODO_LEAD_BLANK_EN
    lz = 8'h00;
`else
    lz = 8'h3F;
`endif

    // Scan sequence from reset, each digit held SC cycles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0001, 4'b0000);
      chk("scan_an_seq", 32'(seg_an), 32'(an_seq[i]));
      chk("scan_cat_zero", 32'(seg_cat), 32'((an_seq[i] == 4'h1) ? 8'h3F : lz));
    end

    // 25 RUN cycles -> two units plus a partial of 5 ticks.
    do_reset();
    run_n(25, 4'b0100, 4'b0001);
    chk("run25_mileage", 32'(mileage_bcd), 32'h0002);
    run_n(4, 4'b0100, 4'b0010);
    chk("partial_kept", 32'(mileage_bcd), 32'h0002);
    run_n(1, 4'b0100, 4'b0010);
    chk("partial_done", 32'(mileage_bcd), 32'h0003);

    // 0009 -> 0010 carry.
    do_reset();
    run_n(99, 4'b0100, 4'b0001);
    chk("pre_carry", 32'(mileage_bcd), 32'h0009);
    run_n(1, 4'b0100, 4'b0001);
    chk("carry_0010", 32'(mileage_bcd), 32'h0010);

    // Left blinker: on one cycle later, toggles every BH cycles; right stays off.
    do_reset();
    blink_pat = 12'b1111_0000_1111;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b0100, 4'b0101);
      chk("blink_left", 32'(led_left), 32'(blink_pat[11-k]));
      chk("blink_right", 32'(led_right), 32'(0));
    end
    step(1'b0, 4'b0100, 4'b0001);
    chk("blink_left_clear", 32'(led_left), 32'(0));

    // Partial unit survives IDLE.
    do_reset();
    run_n(5, 4'b0100, 4'b0001);
    run_n(20, 4'b0010, 4'b0001);
    run_n(4, 4'b0100, 4'b0001);
    chk("idle_hold_before", 32'(mileage_bcd), 32'h0000);
    run_n(1, 4'b0100, 4'b0001);
    chk("idle_hold_after", 32'(mileage_bcd), 32'h0001);

    // Power-off clears mileage and blanks display; scan resumes afterwards.
    do_reset();
    run_n(1230, 4'b0100, 4'b0001);
    chk("odo_0123", 32'(mileage_bcd), 32'h0123);
    step(1'b0, 4'b1000, 4'b0000);
    chk("off_mileage", 32'(mileage_bcd), 32'h0000);
    chk("off_seg_an", 32'(seg_an), 32'h0);
    chk("off_seg_cat", 32'(seg_cat), 32'h00);
    for (int i = 0; i < 4; i++) an_cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0001, 4'b0000);
      for (int d = 0; d < 4; d++) if (seg_an == 4'(1 << d)) an_cnt[d]++;
    end
    for (int d = 0; d < 4; d++) chk("resume_digit_held2", 32'(an_cnt[d]), 32'(2));

    // 0050 display, leading-zero behaviour depends on the build.
    do_reset();
    run_n(500, 4'b0100, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0001, 4'b0000);
      case (seg_an)
        4'b1000: exp_cat = lz;
        4'b0100: exp_cat = lz;
        4'b0010: exp_cat = 8'h6D;
        4'b0001: exp_cat = 8'h3F;
        default: exp_cat = 8'hFF;
      endcase
      chk("odo_0050_digit", 32'(seg_cat), 32'(exp_cat));
    end

    // Randomized traffic, including non-one-hot states and mid-run resets.
    do_reset();
    cmd = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       ds = 4'b0001;
        1:       ds = 4'b0010;
        2:       ds = 4'($urandom);
        default: ds = 4'b0100;
      endcase
      if ($urandom_range(0, 60) == 0) ds = 4'b1000;
      if ($urandom_range(0, 7) == 0) cmd = 4'($urandom);
      step(($urandom_range(0, 199) == 0), ds, cmd);
    end

    // Long-run wrap on the fast-odometer instance.
    w_rst = 1'b0;
    run_n(20010, 4'b0001, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
